squash_redirect_ctrl: RTL and testbench

- Registered controller between the per-unit squash sources and the fetch redirect port.
- Each cycle, selects the oldest valid squash relative to the commit pointer and holds it until fetch accepts it over a val/rdy handshake.
- Merges later, older squashes into the held entry. After each redirect, runs a fixed drain window while the pipeline flushes.

---
 rtl/squash_redirect_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_squash_redirect_ctrl.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/squash_redirect_ctrl.sv
// squash_redirect_ctrl
//   Registered arbiter between per-unit squash sources and the fetch redirect port.
//   Picks the oldest valid squash (age measured from the last committed seq num), holds it
//   until fetch takes it over a val/rdy handshake, merges in strictly older squashes while
//   held, and after each redirect runs a short drain window that filters stale squashes.
//
// Ports
//   clk_i / rst_i          clock, asynchronous active-high reset
//   arb_val_i              per-requester squash valid (single-cycle, no backpressure)
//   arb_seq_num_i          squashing seq num, requester i in slice i
//   arb_target_i           redirect PC, requester i in slice i
//   commit_val_i / commit_seq_num_i   commit notification, moves the age reference
//   redirect_val_o / redirect_rdy_i   held squash handshake toward fetch
//   redirect_seq_num_o / redirect_target_o   held entry
//   busy_o                 controller not idle
//
// Optional build macro SQUASH_REDIRECT_CTRL_PERF_EN adds perf_redirects_o, perf_merged_o and
// perf_dropped_o (32-bit wrapping event counters).
module squash_redirect_ctrl #(
    parameter int unsigned p_num_arb      = 2,
    parameter int unsigned p_seq_num_bits = 5,
    parameter int unsigned p_drain_cycles = 2
) (
    input  logic                                  clk_i,
    input  logic                                  rst_i,
    input  logic [p_num_arb-1:0]                  arb_val_i,
    input  logic [p_num_arb*p_seq_num_bits-1:0]   arb_seq_num_i,
    input  logic [p_num_arb*32-1:0]               arb_target_i,
    input  logic                                  commit_val_i,
    input  logic [p_seq_num_bits-1:0]             commit_seq_num_i,
    output logic                                  redirect_val_o,
    input  logic                                  redirect_rdy_i,
    output logic [p_seq_num_bits-1:0]             redirect_seq_num_o,
    output logic [31:0]                           redirect_target_o,
`ifdef SQUASH_REDIRECT_CTRL_PERF_EN
    output logic [31:0]                           perf_redirects_o,
    output logic [31:0]                           perf_merged_o,
    output logic [31:0]                           perf_dropped_o,
`endif
    output logic                                  busy_o
);

    localparam int unsigned CntW = (p_drain_cycles > 1) ? $clog2(p_drain_cycles) : 1;

    typedef logic [p_seq_num_bits-1:0] seq_t;
    typedef enum logic [1:0] {StIdle, StPend, StDrain} state_e;

    // Modular distance past the last commit; smaller means older.
    function automatic seq_t age(input seq_t x, input seq_t base);
        return seq_t'(x - base - seq_t'(1));
    endfunction

    state_e          state_q, state_d;
    seq_t            last_commit_q;
    seq_t            held_seq_q, held_seq_d;
    logic [31:0]     held_tgt_q, held_tgt_d;
    seq_t            fence_q, fence_d;
    logic [CntW-1:0] drain_cnt_q, drain_cnt_d;

    logic            cand_val;
    seq_t            cand_seq;
    seq_t            cand_age;
    logic [31:0]     cand_tgt;
    seq_t            held_age;
    seq_t            fence_age;
    logic            capture;
    logic            fire;

    // Oldest valid requester; strict compare keeps the lowest index on ties.
    always_comb begin
        cand_val = 1'b0;
        cand_seq = '0;
        cand_age = '0;
        cand_tgt = '0;
        for (int i = 0; i < int'(p_num_arb); i++) begin
            if (arb_val_i[i]) begin
                if (!cand_val ||
                    (age(arb_seq_num_i[i*p_seq_num_bits +: p_seq_num_bits], last_commit_q)
                     < cand_age)) begin
                    cand_val = 1'b1;
                    cand_seq = arb_seq_num_i[i*p_seq_num_bits +: p_seq_num_bits];
                    cand_age = age(arb_seq_num_i[i*p_seq_num_bits +: p_seq_num_bits],
                                   last_commit_q);
                    cand_tgt = arb_target_i[i*32 +: 32];
                end
            end
        end
    end

    assign held_age  = age(held_seq_q, last_commit_q);
    assign fence_age = age(fence_q, last_commit_q);
    assign fire      = (state_q == StPend) && redirect_rdy_i;

    // State register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q       <= StIdle;
            last_commit_q <= '1;
            held_seq_q    <= '0;
            held_tgt_q    <= '0;
            fence_q       <= '0;
            drain_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            held_seq_q  <= held_seq_d;
            held_tgt_q  <= held_tgt_d;
            fence_q     <= fence_d;
            drain_cnt_q <= drain_cnt_d;
            if (commit_val_i) begin
                last_commit_q <= commit_seq_num_i;
            end
        end
    end

    // Next-state
    always_comb begin
        state_d     = state_q;
        held_seq_d  = held_seq_q;
        held_tgt_d  = held_tgt_q;
        fence_d     = fence_q;
        drain_cnt_d = drain_cnt_q;
        capture     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (cand_val) begin
                    capture = 1'b1;
                    state_d = StPend;
                end
            end
            StPend: begin
                // Candidate in the fire cycle is judged against the entry leaving.
                if (cand_val && (cand_age < held_age)) begin
                    capture = 1'b1;
                end
                if (fire) begin
                    fence_d     = held_seq_q;
                    drain_cnt_d = CntW'(p_drain_cycles - 1);
                    state_d     = capture ? StPend : StDrain;
                end
            end
            StDrain: begin
                if (cand_val && (cand_age < fence_age)) begin
                    capture = 1'b1;
                    state_d = StPend;
                end else if (drain_cnt_q == '0) begin
                    state_d = StIdle;
                end else begin
                    drain_cnt_d = drain_cnt_q - 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
        if (capture) begin
            held_seq_d = cand_seq;
            held_tgt_d = cand_tgt;
        end
    end

    // Outputs
    always_comb begin
        redirect_val_o     = (state_q == StPend);
        redirect_seq_num_o = held_seq_q;
        redirect_target_o  = held_tgt_q;
        busy_o             = (state_q != StIdle);
    end

`ifdef SQUASH_REDIRECT_CTRL_PERF_EN
    logic        merge;
    logic [31:0] num_valid;

    // A capture in PEND without a fire replaces a still-pending entry.
    assign merge = (state_q == StPend) && !redirect_rdy_i && capture;

    always_comb begin
        num_valid = '0;
        for (int i = 0; i < int'(p_num_arb); i++) begin
            num_valid = num_valid + 32'(arb_val_i[i]);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            perf_redirects_o <= '0;
            perf_merged_o    <= '0;
            perf_dropped_o   <= '0;
        end else begin
            perf_redirects_o <= perf_redirects_o + 32'(fire);
            perf_merged_o    <= perf_merged_o + 32'(merge);
            perf_dropped_o   <= perf_dropped_o + num_valid - 32'(capture);
        end
    end
`endif

endmodule

// File: tb/tb_squash_redirect_ctrl.sv
module tb_squash_redirect_ctrl;

    localparam int NumArb = 2;
    localparam int SeqW   = 5;
    localparam int SeqMod = 32;
    localparam int Drain  = 2;

    logic                     clk = 1'b0;
    logic                     rst;
    logic [NumArb-1:0]        arb_val;
    logic [NumArb*SeqW-1:0]   arb_seq;
    logic [NumArb*32-1:0]     arb_tgt;
    logic                     commit_val;
    logic [SeqW-1:0]          commit_seq;
    logic                     redirect_val;
    logic                     redirect_rdy;
    logic [SeqW-1:0]          redirect_seq;
    logic [31:0]              redirect_tgt;
    logic                     busy;
`ifdef SQUASH_REDIRECT_CTRL_PERF_EN
    logic [31:0]              perf_redirects;
    logic [31:0]              perf_merged;
    logic [31:0]              perf_dropped;
`endif

    always #5 clk = ~clk;

    squash_redirect_ctrl #(
        .p_num_arb      (NumArb),
        .p_seq_num_bits (SeqW),
        .p_drain_cycles (Drain)
    ) u_dut (
        .clk_i              (clk),
        .rst_i              (rst),
        .arb_val_i          (arb_val),
        .arb_seq_num_i      (arb_seq),
        .arb_target_i       (arb_tgt),
        .commit_val_i       (commit_val),
        .commit_seq_num_i   (commit_seq),
        .redirect_val_o     (redirect_val),
        .redirect_rdy_i     (redirect_rdy),
        .redirect_seq_num_o (redirect_seq),
        .redirect_target_o  (redirect_tgt),
`ifdef SQUASH_REDIRECT_CTRL_PERF_EN
        .perf_redirects_o   (perf_redirects),
        .perf_merged_o      (perf_merged),
        .perf_dropped_o     (perf_dropped),
`endif
        .busy_o             (busy)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: a pending flag plus a count of drain cycles still to run.
    int          m_last;
    bit          m_pend;
    int          m_seq;
    logic [31:0] m_tgt;
    int          m_fence;
    int          m_drain_left;
    int          m_redirects;
    int          m_merged;
    int          m_dropped;

    function automatic int age_of(input int x);
        return (x - m_last - 1 + 2 * SeqMod) % SeqMod;
    endfunction

    task automatic model_reset();
        m_last       = SeqMod - 1;
        m_pend       = 0;
        m_seq        = 0;
        m_tgt        = '0;
        m_fence      = 0;
        m_drain_left = 0;
        m_redirects  = 0;
        m_merged     = 0;
        m_dropped    = 0;
    endtask

    // Advance the model by one clock using the inputs currently driven.
    task automatic model_step();
        int          cidx  = -1;
        int          nval  = 0;
        int          taken = 0;
        int          cseq  = 0;
        logic [31:0] ctgt  = '0;
        for (int i = 0; i < NumArb; i++) begin
            if (arb_val[i]) begin
                nval++;
                if (cidx < 0 || age_of(int'(arb_seq[i*SeqW +: SeqW])) < age_of(cseq)) begin
                    cidx = i;
                    cseq = int'(arb_seq[i*SeqW +: SeqW]);
                    ctgt = arb_tgt[i*32 +: 32];
                end
            end
        end
        if (m_pend) begin
            if (redirect_rdy) begin
                m_redirects++;
                m_fence = m_seq;
                if (cidx >= 0 && age_of(cseq) < age_of(m_seq)) begin
                    taken = 1;
                end else begin
                    m_pend       = 0;
                    m_drain_left = Drain;
                end
            end else if (cidx >= 0 && age_of(cseq) < age_of(m_seq)) begin
                taken = 1;
                m_merged++;
            end
        end else if (m_drain_left > 0) begin
            if (cidx >= 0 && age_of(cseq) < age_of(m_fence)) begin
                taken        = 1;
                m_pend       = 1;
                m_drain_left = 0;
            end else begin
                m_drain_left--;
            end
        end else if (cidx >= 0) begin
            taken  = 1;
            m_pend = 1;
        end
        if (taken != 0) begin
            m_seq = cseq;
            m_tgt = ctgt;
        end
        m_dropped += nval - taken;
        if (commit_val) m_last = int'(commit_seq);
    endtask

    task automatic check_model(input string tag);
        check_eq({tag, ".val"}, 64'(redirect_val), 64'(m_pend));
        check_eq({tag, ".busy"}, 64'(busy), 64'(m_pend || (m_drain_left > 0)));
        if (m_pend) begin
            check_eq({tag, ".seq"}, 64'(redirect_seq), 64'(m_seq));
            check_eq({tag, ".tgt"}, 64'(redirect_tgt), 64'(m_tgt));
        end
    endtask

    // Drive one cycle of inputs at the falling edge, clock it, check at the next falling edge.
    task automatic cyc(input logic [1:0] v, input int s0, input int s1,
                       input logic [31:0] t0, input logic [31:0] t1,
                       input logic rdy, input logic cv, input int cs, input string tag);
        arb_val      = v;
        arb_seq      = {SeqW'(s1), SeqW'(s0)};
        arb_tgt      = {t1, t0};
        redirect_rdy = rdy;
        commit_val   = cv;
        commit_seq   = SeqW'(cs);
        model_step();
        @(posedge clk);
        @(negedge clk);
        check_model(tag);
    endtask

    task automatic idle_cyc(input logic rdy, input string tag);
        cyc(2'b00, 0, 0, 32'h0, 32'h0, rdy, 1'b0, 0, tag);
    endtask

    initial begin
        rst          = 1'b1;
        arb_val      = '0;
        arb_seq      = '0;
        arb_tgt      = '0;
        commit_val   = 1'b0;
        commit_seq   = '0;
        redirect_rdy = 1'b0;
        model_reset();
        #12;
        check_eq("rst.val", 64'(redirect_val), 64'd0);
        check_eq("rst.seq", 64'(redirect_seq), 64'd0);
        check_eq("rst.tgt", 64'(redirect_tgt), 64'd0);
        check_eq("rst.busy", 64'(busy), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // Basic: one squash, fire, two drain cycles.
        cyc(2'b01, 7, 0, 32'h100, 32'h0, 1'b1, 1'b0, 0, "basic");
        check_eq("basic.seq7", 64'(redirect_seq), 64'd7);
        check_eq("basic.tgt100", 64'(redirect_tgt), 64'h100);
        idle_cyc(1'b1, "basic.fire");
        check_eq("basic.drain1", 64'(busy), 64'd1);
        idle_cyc(1'b1, "basic.d2");
        check_eq("basic.drain2", 64'(busy), 64'd1);
        idle_cyc(1'b1, "basic.idle");
        check_eq("basic.idle", 64'(busy), 64'd0);

        // Simultaneous requests and tie-break.
        cyc(2'b11, 9, 4, 32'hA0, 32'hB0, 1'b0, 1'b0, 0, "simul");
        check_eq("simul.seq4", 64'(redirect_seq), 64'd4);
        check_eq("simul.tgtB0", 64'(redirect_tgt), 64'hB0);
        idle_cyc(1'b1, "simul.fire");
        idle_cyc(1'b1, "simul.d2");
        idle_cyc(1'b1, "simul.idle");
        cyc(2'b11, 4, 4, 32'hA0, 32'hB0, 1'b0, 1'b0, 0, "tie");
        check_eq("tie.tgtA0", 64'(redirect_tgt), 64'hA0);
        idle_cyc(1'b1, "tie.fire");
        idle_cyc(1'b1, "tie.d2");
        idle_cyc(1'b1, "tie.idle");

        // Merge under backpressure.
        cyc(2'b01, 12, 0, 32'h120, 32'h0, 1'b0, 1'b0, 0, "merge.hold");
        cyc(2'b10, 0, 3, 32'h0, 32'h300, 1'b0, 1'b0, 0, "merge.older");
        check_eq("merge.seq3", 64'(redirect_seq), 64'd3);
        cyc(2'b01, 20, 0, 32'h200, 32'h0, 1'b0, 1'b0, 0, "merge.younger");
        check_eq("merge.keep3", 64'(redirect_seq), 64'd3);
        idle_cyc(1'b1, "merge.fire");
        check_eq("merge.once", 64'(redirect_val), 64'd0);
        idle_cyc(1'b1, "merge.d2");
        idle_cyc(1'b1, "merge.idle");

        // Seq-num wrap.
        cyc(2'b00, 0, 0, 32'h0, 32'h0, 1'b0, 1'b1, 29, "wrap.commit");
        cyc(2'b11, 1, 31, 32'h11, 32'h31, 1'b0, 1'b0, 0, "wrap");
        check_eq("wrap.seq31", 64'(redirect_seq), 64'd31);
        idle_cyc(1'b1, "wrap.fire");
        idle_cyc(1'b1, "wrap.d2");
        idle_cyc(1'b1, "wrap.idle");

        // Drain fence: younger squash dropped, older one captured.
        cyc(2'b01, 10, 0, 32'h1000, 32'h0, 1'b0, 1'b0, 0, "fence.hold");
        idle_cyc(1'b1, "fence.fire");
        cyc(2'b01, 15, 0, 32'h1500, 32'h0, 1'b0, 1'b0, 0, "fence.stale");
        check_eq("fence.stale_val", 64'(redirect_val), 64'd0);
        cyc(2'b10, 0, 6, 32'h0, 32'h600, 1'b0, 1'b0, 0, "fence.older");
        check_eq("fence.seq6", 64'(redirect_seq), 64'd6);
        idle_cyc(1'b1, "fence.fire2");
        idle_cyc(1'b1, "fence.d2");
        idle_cyc(1'b1, "fence.idle");

        // Async reset mid-PEND.
        cyc(2'b01, 5, 0, 32'h500, 32'h0, 1'b0, 1'b0, 0, "areset.pend");
        #2 rst = 1'b1;
        #1;
        check_eq("areset.val", 64'(redirect_val), 64'd0);
        check_eq("areset.busy", 64'(busy), 64'd0);
        model_reset();
        #1 rst = 1'b0;
        @(negedge clk);
        cyc(2'b11, 31, 0, 32'hF1, 32'hF0, 1'b0, 1'b0, 0, "areset.after");
        check_eq("areset.seq0", 64'(redirect_seq), 64'd0);
        check_eq("areset.tgtF0", 64'(redirect_tgt), 64'hF0);

        // Random traffic against the model.
        for (int n = 0; n < 2000; n++) begin
            logic [1:0] v;
            v = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            cyc(v, int'($urandom_range(0, SeqMod - 1)), int'($urandom_range(0, SeqMod - 1)),
                $urandom, $urandom, logic'($urandom_range(0, 2) != 0),
                logic'($urandom_range(0, 3) == 0), int'($urandom_range(0, SeqMod - 1)), "rand");
        end

`ifdef SQUASH_REDIRECT_CTRL_PERF_EN
        check_eq("perf.redirects", 64'(perf_redirects), 64'(m_redirects));
        check_eq("perf.merged", 64'(perf_merged), 64'(m_merged));
        check_eq("perf.dropped", 64'(perf_dropped), 64'(m_dropped));
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
